// File: rtl/onewire_slave_responder.sv
// 1-wire slave responder: detects master reset pulses, answers with a presence
// pulse, receives one command byte and answers Read ROM (0x33) with a 64-bit ID.
module onewire_slave_responder #(
  parameter int unsigned CLK_PER_US  = 48,
  parameter int unsigned RST_MIN_US  = 400,
  parameter int unsigned PD_WAIT_US  = 30,
  parameter int unsigned PD_LEN_US   = 120,
  parameter int unsigned SAMPLE_US   = 30,
  parameter int unsigned RD0_HOLD_US = 30,
  parameter logic [63:0] ROM_ID      = 64'h2800_0000_0000_0001
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_owr,
  output logic       o_owr,
  output logic       o_presence,
  output logic       o_cmd_valid,
  output logic [7:0] o_cmd,
  output logic       o_busy
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned RstCyc    = RST_MIN_US * CLK_PER_US;
  localparam int unsigned PdWaitCyc = PD_WAIT_US * CLK_PER_US;
  localparam int unsigned PdLenCyc  = PD_LEN_US * CLK_PER_US;
  localparam int unsigned SampleCyc = SAMPLE_US * CLK_PER_US;
  localparam int unsigned HoldCyc   = RD0_HOLD_US * CLK_PER_US;
  localparam int unsigned MaxCyc    = max2(max2(RstCyc, PdWaitCyc),
                                           max2(max2(PdLenCyc, SampleCyc), HoldCyc));
  localparam int unsigned CntW      = $clog2(MaxCyc) + 1;

  localparam logic [CntW-1:0] LowSat     = CntW'(RstCyc);
  localparam logic [CntW-1:0] PdWaitLast = CntW'(PdWaitCyc - 1);
  localparam logic [CntW-1:0] PdLenLast  = CntW'(PdLenCyc - 1);
  localparam logic [CntW-1:0] SampleLast = CntW'(SampleCyc - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HoldCyc - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  typedef enum logic [2:0] {
    StIdle, StPdWait, StPdDrive, StPdRel, StCmdRx, StRomTx, StDone
  } state_e;

  logic            s_meta_q, s_q, s_prev_q;
  logic [CntW-1:0] low_cnt_q, low_cnt_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] tmr_q, tmr_d;
  logic [6:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            slot_q, slot_d;
  logic            owr_q, owr_d;
  logic            pres_q, pres_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [7:0]      cmd_q, cmd_d;

  logic       rise, fall, rst_det, rom_bit;
  logic [7:0] cmd_next;

  assign rise     = s_q & ~s_prev_q;
  assign fall     = ~s_q & s_prev_q;
  // Low counter value before the rising edge clears it decides reset detection.
  assign rst_det  = rise && (low_cnt_q == LowSat);
  assign rom_bit  = ROM_ID[bit_cnt_q[5:0]];
  assign cmd_next = {s_q, shift_q[7:1]};

  // Two-flop synchronizer plus edge-detect register; idle bus level is high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_meta_q <= 1'b1;
      s_q      <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      s_meta_q <= i_owr;
      s_q      <= s_meta_q;
      s_prev_q <= s_q;
    end
  end

  // Low-time counter; held at zero while we drive so our own pulses never look like a reset.
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (owr_q || rise) begin
      low_cnt_d = '0;
    end else if (!s_q && (low_cnt_q != LowSat)) begin
      low_cnt_d = low_cnt_q + CntOne;
    end
  end

  // Next-state and output logic; reset detection preempts every state.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    slot_d      = slot_q;
    owr_d       = owr_q;
    pres_d      = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    if (rst_det) begin
      state_d   = StPdWait;
      tmr_d     = '0;
      bit_cnt_d = '0;
      shift_d   = '0;
      slot_d    = 1'b0;
      owr_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StPdWait: begin
          if (tmr_q == PdWaitLast) begin
            state_d = StPdDrive;
            tmr_d   = '0;
            pres_d  = 1'b1;
            owr_d   = 1'b1;
          end else begin
            tmr_d = tmr_q + CntOne;
          end
        end
        StPdDrive: begin
          if (tmr_q == PdLenLast) begin
            state_d = StPdRel;
            tmr_d   = '0;
            owr_d   = 1'b0;
          end else begin
            tmr_d = tmr_q + CntOne;
          end
        end
        StPdRel: begin
          if (s_q) begin
            state_d   = StCmdRx;
            bit_cnt_d = '0;
            slot_d    = 1'b0;
          end
        end
        StCmdRx: begin
          if (slot_q) begin
            if (tmr_q == SampleLast) begin
              slot_d    = 1'b0;
              shift_d   = cmd_next;
              bit_cnt_d = bit_cnt_q + 7'd1;
              if (bit_cnt_q == 7'd7) begin
                cmd_d       = cmd_next;
                cmd_valid_d = 1'b1;
                bit_cnt_d   = '0;
                state_d     = (cmd_next == 8'h33) ? StRomTx : StDone;
              end
            end else begin
              tmr_d = tmr_q + CntOne;
            end
          end else if (fall) begin
            slot_d = 1'b1;
            tmr_d  = '0;
          end
        end
        StRomTx: begin
          if (slot_q) begin
            if (tmr_q == HoldLast) begin
              slot_d    = 1'b0;
              owr_d     = 1'b0;
              bit_cnt_d = bit_cnt_q + 7'd1;
            end else begin
              tmr_d = tmr_q + CntOne;
            end
          end else if (bit_cnt_q == 7'd64) begin
            // Last slot is over once the bus is back high.
            if (s_q) begin
              state_d = StDone;
            end
          end else if (fall) begin
            slot_d = 1'b1;
            tmr_d  = '0;
            owr_d  = ~rom_bit;
          end
        end
        StDone: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered-output flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      low_cnt_q   <= '0;
      state_q     <= StIdle;
      tmr_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      slot_q      <= 1'b0;
      owr_q       <= 1'b0;
      pres_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
    end else begin
      low_cnt_q   <= low_cnt_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      slot_q      <= slot_d;
      owr_q       <= owr_d;
      pres_q      <= pres_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign o_owr       = owr_q;
  assign o_presence  = pres_q;
  assign o_cmd_valid = cmd_valid_q;
  assign o_cmd       = cmd_q;
  assign o_busy      = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_onewire_slave_responder.sv
// Directed bench for onewire_slave_responder, run at 2 clocks per microsecond.
module tb_onewire_slave_responder;

  localparam int unsigned Cpu   = 2;
  localparam logic [63:0] RomId = 64'h2800_0000_0000_0001;

  logic       i_clk = 1'b0;
  logic       i_rst, m_low, i_owr;
  logic       o_owr, o_presence, o_cmd_valid, o_busy;
  logic [7:0] o_cmd;

  int vectors = 0, miscompares = 0;
  int pres_seen = 0, valid_seen = 0, owr_seen = 0;
  logic [63:0] rom_exp, cap;
  logic        v;
  int          h, p0, c0, w0;

  onewire_slave_responder #(.CLK_PER_US(Cpu)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_owr      (i_owr),
    .o_owr      (o_owr),
    .o_presence (o_presence),
    .o_cmd_valid(o_cmd_valid),
    .o_cmd      (o_cmd),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Open-drain bus with pull-up: low if master or slave pulls it.
  assign i_owr = ~(m_low | o_owr);

  // Event counters sampled on the inactive edge.
  always @(negedge i_clk) begin
    if (o_presence)  pres_seen++;
    if (o_cmd_valid) valid_seen++;
    if (o_owr)       owr_seen++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // 480 us reset pulse; presence follows 2 sync + 1 edge register + 30 us wait,
  // then the slave drives for exactly 120 us.
  task automatic bus_reset();
    int n, hi;
    m_low = 1'b1;
    cyc(480 * Cpu);
    m_low = 1'b0;
    n = 0;
    while (!o_presence && n < 200 * Cpu) begin
      cyc(1);
      n++;
    end
    check("presence_latency", n, 30 * Cpu + 3);
    check("busy_after_release", o_busy, 1'b1);
    hi = 0;
    while (o_owr && hi < 400 * Cpu) begin
      hi++;
      cyc(1);
    end
    check("presence_len", hi, 120 * Cpu);
    cyc(10);
  endtask

  // Write slots, 70 us each, LSB first.
  task automatic write_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      m_low = 1'b1;
      cyc(b[i] ? 6 * Cpu : 60 * Cpu);
      m_low = 1'b0;
      cyc(b[i] ? 64 * Cpu : 10 * Cpu);
    end
  endtask

  // Read slot: 6 us master low, bus sampled at 15 us, slave drive time counted.
  task automatic read_bit(output logic bv, output int hold);
    m_low = 1'b1;
    bv    = 1'b1;
    hold  = 0;
    for (int t = 0; t < 70 * Cpu; t++) begin
      cyc(1);
      if (t == 6 * Cpu - 1)  m_low = 1'b0;
      if (t == 15 * Cpu - 1) bv = i_owr;
      if (o_owr) hold++;
    end
  endtask

  initial begin
    rom_exp = RomId;
    i_rst   = 1'b1;
    m_low   = 1'b0;
    cyc(5);
    check("rst_owr", o_owr, 1'b0);
    check("rst_presence", o_presence, 1'b0);
    check("rst_cmd_valid", o_cmd_valid, 1'b0);
    check("rst_cmd", o_cmd, 8'h00);
    check("rst_busy", o_busy, 1'b0);
    i_rst = 1'b0;
    cyc(5);

    // Short 200 us pulse in idle: not a reset.
    p0 = pres_seen; w0 = owr_seen;
    m_low = 1'b1;
    cyc(200 * Cpu);
    m_low = 1'b0;
    cyc(200 * Cpu);
    check("short_no_presence", pres_seen - p0, 0);
    check("short_no_drive", owr_seen - w0, 0);
    check("short_busy", o_busy, 1'b0);

    // Reset/presence, then a non-ROM command.
    p0 = pres_seen;
    bus_reset();
    check("presence_once", pres_seen - p0, 1);
    c0 = valid_seen;
    write_byte(8'hCC);
    cyc(4);
    check("cc_valid_one_cycle", valid_seen - c0, 1);
    check("cc_cmd", o_cmd, 8'hCC);
    check("cc_done_busy", o_busy, 1'b0);
    c0 = valid_seen; w0 = owr_seen;
    write_byte(8'h33);
    read_bit(v, h);
    read_bit(v, h);
    check("done_ignores_valid", valid_seen - c0, 0);
    check("done_ignores_drive", owr_seen - w0, 0);
    check("done_cmd_kept", o_cmd, 8'hCC);

    // Read ROM: full 64-bit ID.
    bus_reset();
    write_byte(8'h33);
    check("rom_cmd", o_cmd, 8'h33);
    check("rom_busy", o_busy, 1'b1);
    cap = '0;
    for (int i = 0; i < 64; i++) begin
      read_bit(v, h);
      cap[i] = v;
      check("rom_hold", h, rom_exp[i] ? 0 : 30 * Cpu);
    end
    check("rom_id", cap, rom_exp);
    cyc(4);
    check("rom_done_busy", o_busy, 1'b0);

    // Reset during ROM transmit restarts from bit 0.
    bus_reset();
    write_byte(8'h33);
    cap = '0;
    for (int i = 0; i < 21; i++) begin
      read_bit(v, h);
      cap[i] = v;
    end
    check("rom_partial", cap[20:0], rom_exp[20:0]);
    p0 = pres_seen;
    bus_reset();
    check("rom_rst_presence", pres_seen - p0, 1);
    write_byte(8'h33);
    cap = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(v, h);
      cap[i] = v;
    end
    check("rom_restart_byte0", cap[7:0], rom_exp[7:0]);

    // Synchronous reset while driving the presence pulse.
    m_low = 1'b1;
    cyc(480 * Cpu);
    m_low = 1'b0;
    cyc(30 * Cpu + 3 + 50);
    check("pd_drive_owr", o_owr, 1'b1);
    i_rst = 1'b1;
    cyc(1);
    check("irst_owr", o_owr, 1'b0);
    check("irst_busy", o_busy, 1'b0);
    check("irst_cmd", o_cmd, 8'h00);
    i_rst = 1'b0;
    p0 = pres_seen; w0 = owr_seen;
    cyc(200 * Cpu);
    check("irst_idle_drive", owr_seen - w0, 0);
    check("irst_idle_presence", pres_seen - p0, 0);
    check("irst_idle_busy", o_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
